// File: rtl/dwrr_pkg.sv
// Shared types and helpers for the deficit weighted round-robin packet arbiter.
// Holds the FSM state encoding and the saturating deficit add.
package dwrr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    SERVE = 2'd2
  } state_t;

  localparam int unsigned QWID_DFLT = 8;
  localparam int unsigned DEF_MAX   = (1 << QWID_DFLT) - 1;

  // Widths up to 32 bits; the caller passes its own ceiling and truncates the result.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_v);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_v}) ? max_v : sum[31:0];
  endfunction

endpackage

// File: rtl/rr_next_finder.sv
// Rotating priority search: first set request strictly after rr_ptr, wrapping,
// with rr_ptr itself checked last.
module rr_next_finder #(
  parameter int NUM_REQS = 4,
  parameter int CNTWID   = $clog2(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] reqs,
  input  logic [CNTWID-1:0]   rr_ptr,
  output logic [CNTWID-1:0]   idx,
  output logic                found
);

  logic [2*NUM_REQS-1:0] dbl;
  logic [2*NUM_REQS-1:0] rot;
  logic [CNTWID:0]       start;
  logic [CNTWID:0]       pos;
  logic [CNTWID-1:0]     hit;

  assign dbl   = {reqs, reqs};
  assign start = {1'b0, rr_ptr} + 1'b1;
  assign rot   = dbl >> start;

  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    found = 1'b0;
    hit   = '0;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        hit   = CNTWID'(k);
      end
    end
    pos = start + {1'b0, hit};
    idx = (pos >= (CNTWID+1)'(NUM_REQS)) ? CNTWID'(pos - (CNTWID+1)'(NUM_REQS))
                                         : CNTWID'(pos);
  end

endmodule

// File: rtl/dwrr_pkt_arbiter.sv
// Deficit weighted round-robin arbiter for multi-beat packets: one turn per
// requestor, grant held for whole packets, deficit debited by packet length.
module dwrr_pkt_arbiter
  import dwrr_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int QWID     = QWID_DFLT,
  parameter int LENWID   = 4,
  parameter int CNTWID   = $clog2(NUM_REQS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       blk,
  input  logic [NUM_REQS-1:0]        reqs,
  input  logic [NUM_REQS*LENWID-1:0] pkt_len,
  input  logic [NUM_REQS*QWID-1:0]   input_quantums,
  input  logic                       out_ready,
  output logic [NUM_REQS-1:0]        gnt,
  output logic                       gnt_last,
  output logic [CNTWID-1:0]          sel_idx
);

  localparam logic [31:0] Q_MAX = 32'((64'd1 << QWID) - 64'd1);

  state_t              state_q, state_d;
  logic [CNTWID-1:0]   sel_q, sel_d;
  logic [CNTWID-1:0]   rr_ptr_q, rr_ptr_d;
  logic [LENWID-1:0]   len_q, len_d;
  logic [LENWID-1:0]   beat_cnt_q, beat_cnt_d;
  logic [QWID-1:0]     def_q [NUM_REQS];
  logic [QWID-1:0]     def_d [NUM_REQS];

  logic [QWID-1:0]     quantum [NUM_REQS];
  logic [LENWID-1:0]   len_in  [NUM_REQS];
  logic [CNTWID-1:0]   nxt_idx;
  logic                nxt_found;
  logic [LENWID-1:0]   len_cur;
  logic                serving;
  logic                last_beat;

  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      quantum[i] = input_quantums[i*QWID +: QWID];
      len_in[i]  = pkt_len[i*LENWID +: LENWID];
    end
  end

  rr_next_finder #(
    .NUM_REQS (NUM_REQS),
    .CNTWID   (CNTWID)
  ) u_finder (
    .reqs   (reqs),
    .rr_ptr (rr_ptr_q),
    .idx    (nxt_idx),
    .found  (nxt_found)
  );

  // A zero-length head packet still occupies one beat on the link.
  assign len_cur   = (len_in[sel_q] == '0) ? LENWID'(1) : len_in[sel_q];
  assign serving   = (state_q == SERVE);
  assign last_beat = (beat_cnt_q == len_q - LENWID'(1));

  always_comb begin
    gnt = '0;
    if (serving) gnt[sel_q] = 1'b1;
  end

  assign gnt_last = serving & last_beat;
  assign sel_idx  = sel_q;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    rr_ptr_d   = rr_ptr_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    def_d      = def_q;
    if (!blk) begin
      case (state_q)
        IDLE: begin
          if (nxt_found) begin
            sel_d          = nxt_idx;
            def_d[nxt_idx] = QWID'(sat_add(32'(def_q[nxt_idx]), 32'(quantum[nxt_idx]), Q_MAX));
            state_d        = CHECK;
          end
        end
        CHECK: begin
          if (!reqs[sel_q]) begin
            def_d[sel_q] = '0;
            rr_ptr_d     = sel_q;
            state_d      = IDLE;
          end else if (32'(len_cur) > 32'(def_q[sel_q])) begin
            rr_ptr_d = sel_q;
            state_d  = IDLE;
          end else begin
            len_d      = len_cur;
            beat_cnt_d = '0;
            state_d    = SERVE;
          end
        end
        SERVE: begin
          if (out_ready) begin
            beat_cnt_d = beat_cnt_q + LENWID'(1);
            if (last_beat) begin
              // Cannot underflow: CHECK only enters SERVE when len_q <= deficit.
              def_d[sel_q] = def_q[sel_q] - QWID'(len_q);
              state_d      = CHECK;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the deficit array is reset too: a stale deficit would hand out unearned bandwidth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      rr_ptr_q   <= CNTWID'(NUM_REQS - 1);
      len_q      <= '0;
      beat_cnt_q <= '0;
      for (int i = 0; i < NUM_REQS; i++) def_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      rr_ptr_q   <= rr_ptr_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      for (int i = 0; i < NUM_REQS; i++) def_q[i] <= def_d[i];
    end
  end

endmodule

// File: tb/tb_dwrr_pkt_arbiter.sv
// Self-checking bench: table-driven scenarios scored against a turn-level DWRR
// model, plus hand sequences for latency, backpressure, stall and reset.
module tb_dwrr_pkt_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        blk;
  logic [3:0]  reqs;
  logic [15:0] pkt_len;
  logic [31:0] input_quantums;
  logic        out_ready;
  logic [3:0]  gnt;
  logic        gnt_last;
  logic [1:0]  sel_idx;

  dwrr_pkt_arbiter #(
    .NUM_REQS (4),
    .QWID     (8),
    .LENWID   (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .blk            (blk),
    .reqs           (reqs),
    .pkt_len        (pkt_len),
    .input_quantums (input_quantums),
    .out_ready      (out_ready),
    .gnt            (gnt),
    .gnt_last       (gnt_last),
    .sel_idx        (sel_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  reqs;
    logic [15:0] lens;
    logic [31:0] quants;
    int          npkts;
    logic [3:0]  first_gnt;
  } vec_t;

  typedef struct {
    logic [3:0] gnt;
    logic       last;
  } exp_t;

  vec_t       vecs[6];
  exp_t       sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic       mon_en = 1'b0;
  logic       got_first = 1'b0;
  logic [3:0] first_gnt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    blk            = 1'b0;
    reqs           = '0;
    pkt_len        = '0;
    input_quantums = '0;
    out_ready      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_gnt(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (gnt != '0) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
    check(name, 32'(ok), 32'd1);
  endtask

  // Turn-level reference: inputs held constant, one entry per granted beat.
  task automatic model_push(input vec_t v);
    int def[4];
    int ptr;
    int pk;
    int j;
    int len;
    int c;
    for (int i = 0; i < 4; i++) def[i] = 0;
    ptr = 3;
    pk  = 0;
    for (int t = 0; t < 64 && pk < v.npkts; t++) begin
      j = -1;
      for (int k = 1; k <= 4; k++) begin
        c = (ptr + k) % 4;
        if (v.reqs[c] && j < 0) j = c;
      end
      if (j < 0) break;
      def[j] = def[j] + int'(v.quants[j*8 +: 8]);
      if (def[j] > 255) def[j] = 255;
      len = int'(v.lens[j*4 +: 4]);
      if (len == 0) len = 1;
      while (pk < v.npkts && len <= def[j]) begin
        for (int b = 0; b < len; b++) begin
          exp_t e;
          e.gnt  = 4'b0001 << j;
          e.last = (b == len - 1);
          sb.push_back(e);
        end
        def[j] = def[j] - len;
        pk++;
      end
      ptr = j;
    end
  endtask

  always @(negedge clk) begin
    if (!mon_en) begin
      got_first = 1'b0;
    end else if (!rst && gnt != '0) begin
      check("onehot", 32'($countones(gnt)), 32'd1);
      if (out_ready && !blk) begin
        if (!got_first) begin
          first_gnt = gnt;
          got_first = 1'b1;
        end
        if (sb.size() == 0) begin
          check("sb_extra_beat", 32'(gnt), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_gnt", 32'(gnt), 32'(e.gnt));
          check("sb_last", 32'(gnt_last), 32'(e.last));
        end
      end
    end
  end

  initial begin
    vecs[0] = '{4'b0001, 16'h0003, 32'h0000_0008, 4,  4'b0001};
    vecs[1] = '{4'b1010, 16'h4444, 32'h0404_0404, 6,  4'b0010};
    vecs[2] = '{4'b0001, 16'h0005, 32'h0000_0002, 2,  4'b0001};
    vecs[3] = '{4'b1111, 16'h4032, 32'h0207_0503, 12, 4'b0001};
    vecs[4] = '{4'b0110, 16'h0320, 32'h0006_0000, 4,  4'b0100};
    vecs[5] = '{4'b0001, 16'h000F, 32'h0000_00C8, 14, 4'b0001};

    do_reset();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_gnt_last", 32'(gnt_last), 32'd0);
    check("rst_sel_idx", 32'(sel_idx), 32'd0);

    // Scoreboarded scenarios.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      reqs           = vecs[r].reqs;
      pkt_len        = vecs[r].lens;
      input_quantums = vecs[r].quants;
      out_ready      = 1'b1;
      model_push(vecs[r]);
      mon_en = 1'b1;
      for (int cyc = 0; cyc < 2000; cyc++) begin
        @(posedge clk);
        if (sb.size() == 0) break;
      end
      mon_en = 1'b0;
      check($sformatf("row%0d_drained", r), 32'(sb.size()), 32'd0);
      check($sformatf("row%0d_first_gnt", r), 32'(first_gnt), 32'(vecs[r].first_gnt));
      sb.delete();
      @(negedge clk);
    end

    // Latency, deficit debit and the one-cycle gap between packets.
    do_reset();
    reqs = 4'b0001; pkt_len = 16'h0003; input_quantums = 32'h0000_0008; out_ready = 1'b1;
    step(1); check("lat_e1_gnt", 32'(gnt), 32'd0);
    step(1); check("lat_e2_gnt", 32'(gnt), 32'b0001);
    check("lat_e2_last", 32'(gnt_last), 32'd0);
    step(2); check("beat3_last", 32'(gnt_last), 32'd1);
    step(1); check("gap_gnt", 32'(gnt), 32'd0);
    check("def_after_pkt1", 32'(dut.def_q[0]), 32'd5);
    step(1); check("pkt2_gnt", 32'(gnt), 32'b0001);
    step(3); check("def_after_pkt2", 32'(dut.def_q[0]), 32'd2);
    step(1); check("turn_end_gnt", 32'(gnt), 32'd0);
    check("turn_end_def_kept", 32'(dut.def_q[0]), 32'd2);

    // Backpressure: accept pattern 1,0,0,1,1 on a 3-beat packet.
    do_reset();
    reqs = 4'b0001; pkt_len = 16'h0003; input_quantums = 32'h0000_0008;
    wait_gnt("bp_wait_gnt");
    begin
      logic [4:0] pat;
      int         acc;
      pat = 5'b11001;
      acc = 0;
      for (int k = 0; k < 5; k++) begin
        out_ready = pat[k];
        check($sformatf("bp_gnt_%0d", k), 32'(gnt), 32'b0001);
        check($sformatf("bp_last_%0d", k), 32'(gnt_last), 32'(acc == 2));
        if (pat[k]) acc++;
        step(1);
      end
    end
    check("bp_done_gnt", 32'(gnt), 32'd0);

    // Global stall mid-packet.
    do_reset();
    reqs = 4'b0001; pkt_len = 16'h0003; input_quantums = 32'h0000_0008; out_ready = 1'b1;
    wait_gnt("blk_wait_gnt");
    step(1);
    blk = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(1);
      check($sformatf("blk_gnt_%0d", k), 32'(gnt), 32'b0001);
      check($sformatf("blk_beat_%0d", k), 32'(dut.beat_cnt_q), 32'd1);
      check($sformatf("blk_def_%0d", k), 32'(dut.def_q[0]), 32'd8);
    end
    blk = 1'b0;
    check("blk_rel_last", 32'(gnt_last), 32'd0);
    step(1); check("blk_resume_last", 32'(gnt_last), 32'd1);
    step(1); check("blk_resume_def", 32'(dut.def_q[0]), 32'd5);

    // Asynchronous reset mid-packet.
    do_reset();
    reqs = 4'b0010; pkt_len = 16'h0030; input_quantums = 32'h0000_0800; out_ready = 1'b1;
    wait_gnt("arst_wait_gnt");
    check("arst_pre_gnt", 32'(gnt), 32'b0010);
    #2 rst = 1'b1;
    #1;
    check("arst_gnt_dropped", 32'(gnt), 32'd0);
    check("arst_def1", 32'(dut.def_q[1]), 32'd0);
    check("arst_sel", 32'(sel_idx), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    reqs = 4'b0101; pkt_len = 16'h2222; input_quantums = 32'h0808_0808;
    wait_gnt("arst_regnt_wait");
    check("arst_regnt_req0", 32'(gnt), 32'b0001);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
